sample_burst_streamer: RTL and testbench

//  Parametrised successor to the ADC-to-FX3 data generator. Captures ADC samples on a

---
 rtl/dd_stream_pkg.sv | 18 +
 rtl/sample_burst_streamer_if.sv | 32 +++
 rtl/dd_sync_fifo.sv | 82 ++++++++
 rtl/sample_burst_streamer.sv | 157 +++++++++++++++
 tb/tb_sample_burst_streamer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dd_stream_pkg.sv
// Shared types and constants for the ADC sample burst streamer.
package dd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int DEFAULT_ADC_WIDTH = 10;
    localparam int DEFAULT_OUT_WIDTH = 16;

    // Width of a counter that must hold values 0..burst_words.
    function automatic int burst_cnt_width(input int burst_words);
        return $clog2(burst_words + 1);
    endfunction

endpackage

// File: rtl/sample_burst_streamer_if.sv
// ADC-side capture inputs and FX3-side burst handshake of the sample burst streamer.
interface sample_burst_streamer_if #(
    parameter int ADC_WIDTH       = 10,
    parameter int OUT_WIDTH       = 16,
    parameter int FIFO_DEPTH_LOG2 = 14
);
    // Handshake: a sample is offered when sampleStrobe=1 in a cycle and is taken on that edge
    // (no back-pressure; a full FIFO drops it and flags overflow). On the FX3 side dataOut is
    // always the FIFO head; a word is consumed in every cycle with readData=1, and
    // dataAvailable=1 promises that a full burst of words is already buffered.
    logic                       sampleStrobe;
    logic [ADC_WIDTH-1:0]       adcData;
    logic                       collectData;
    logic                       testMode;
    logic                       readData;
    logic                       dataAvailable;
    logic [OUT_WIDTH-1:0]       dataOut;
    logic                       overflow;
    logic                       underflow;
    logic [FIFO_DEPTH_LOG2:0]   fillLevel;

    modport master (
        output sampleStrobe, adcData, collectData, testMode, readData,
        input  dataAvailable, dataOut, overflow, underflow, fillLevel
    );

    modport slave (
        input  sampleStrobe, adcData, collectData, testMode, readData,
        output dataAvailable, dataOut, overflow, underflow, fillLevel
    );

endinterface

// File: rtl/dd_sync_fifo.sv
// Single-clock RAM FIFO with registered first-word-fall-through head and fill count.
module dd_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  accepted,
    output logic                  empty_pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   fill
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   remaining;
    logic [DEPTH_LOG2:0]   count_next;
    logic [WIDTH-1:0]      head_q;
    logic                  pop_eff;
    logic                  push_eff;

    // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
    always_comb begin
        pop_eff    = pop && (count != '0);
        push_eff   = push && ((count != FULL_COUNT) || pop_eff);
        rd_next    = pop_eff ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
        remaining  = pop_eff ? count - CW'(1) : count;
        count_next = push_eff ? remaining + CW'(1) : remaining;
    end

    assign accepted  = push_eff;
    assign empty_pop = pop && (count == '0);
    assign head      = head_q;
    assign fill      = count;

    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
        end
    end

    // The head only loads words already resident in RAM, which makes an empty-FIFO push
    // appear on the head two clocks later and keeps the head at zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
        end else if (flush || (remaining == '0)) begin
            head_q <= '0;
        end else begin
            head_q <= mem[rd_next];
        end
    end

endmodule

// File: rtl/sample_burst_streamer.sv
// ADC sample capture, FIFO buffering and fixed-length FX3 burst handshake.
// Optional build macro DD_TEST_PATTERN_EN adds a test counter selected by testMode.
module sample_burst_streamer
    import dd_stream_pkg::*;
#(
    parameter int ADC_WIDTH       = DEFAULT_ADC_WIDTH,
    parameter int OUT_WIDTH       = DEFAULT_OUT_WIDTH,
    parameter int FIFO_DEPTH_LOG2 = 14,
    parameter int BURST_WORDS     = 8192
) (
    input  logic                    inclk,
    input  logic                    reset,
    sample_burst_streamer_if.slave  bus,
    output state_t                  state
);
    localparam int BCW = burst_cnt_width(BURST_WORDS);
    localparam logic [BCW-1:0]             BURST_LAST = BCW'(BURST_WORDS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   BURST_FILL = (FIFO_DEPTH_LOG2 + 1)'(BURST_WORDS);

    state_t                    state_q;
    state_t                    state_next;
    logic [BCW-1:0]            burst_cnt_q;
    logic [BCW-1:0]            burst_cnt_next;
    logic                      avail_q;
    logic                      avail_next;
    logic                      entry_pop;
    logic                      overflow_q;
    logic                      underflow_q;
    logic                      push;
    logic                      pop;
    logic                      flush;
    logic                      accepted;
    logic                      empty_pop;
    logic [ADC_WIDTH-1:0]      sample;
    logic [FIFO_DEPTH_LOG2:0]  fill;

    assign push  = bus.sampleStrobe && bus.collectData;
    assign pop   = bus.readData && bus.collectData;
    assign flush = !bus.collectData;

`ifdef DD_TEST_PATTERN_EN
    logic [ADC_WIDTH-1:0] pattern_q;

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
        end else if (!bus.collectData) begin
            pattern_q <= '0;
        end else if (accepted && bus.testMode) begin
            pattern_q <= pattern_q + ADC_WIDTH'(1);
        end
    end

    assign sample = bus.testMode ? pattern_q : bus.adcData;
`else
    logic unused_test_mode;
    assign unused_test_mode = bus.testMode;
    assign sample           = bus.adcData;
`endif

    dd_sync_fifo #(
        .WIDTH      (OUT_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (inclk),
        .rst       (reset),
        .push      (push),
        .push_data (OUT_WIDTH'(sample)),
        .pop       (pop),
        .flush     (flush),
        .accepted  (accepted),
        .empty_pop (empty_pop),
        .head      (bus.dataOut),
        .fill      (fill)
    );

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            avail_q     <= 1'b0;
        end else begin
            state_q     <= state_next;
            burst_cnt_q <= burst_cnt_next;
            avail_q     <= avail_next;
        end
    end

    // burst_cnt_q counts pops already taken in the current burst, the entry pop included.
    always_comb begin
        state_next     = state_q;
        burst_cnt_next = burst_cnt_q;
        entry_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.collectData) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!bus.collectData) begin
                    state_next = IDLE;
                end else if (bus.readData && avail_q) begin
                    entry_pop = 1'b1;
                    if (BURST_WORDS == 1) begin
                        state_next = ARMED;
                    end else begin
                        state_next     = BURST;
                        burst_cnt_next = BCW'(1);
                    end
                end
            end
            BURST: begin
                if (!bus.collectData) begin
                    state_next     = IDLE;
                    burst_cnt_next = '0;
                end else if (bus.readData) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        state_next     = ARMED;
                        burst_cnt_next = '0;
                    end else begin
                        burst_cnt_next = burst_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
        endcase
        avail_next = bus.collectData && (state_q == ARMED) && !entry_pop && (fill >= BURST_FILL);
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!bus.collectData) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !accepted) begin
                overflow_q <= 1'b1;
            end
            if (empty_pop) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.dataAvailable = avail_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
    assign bus.fillLevel     = fill;
    assign state             = state_q;

endmodule

// File: tb/tb_sample_burst_streamer.sv
// Directed bench for sample_burst_streamer at default parameters (10->16 bit, 16K FIFO, 8K bursts).
module tb_sample_burst_streamer;
    import dd_stream_pkg::*;

    localparam int ADC_W   = 10;
    localparam int OUT_W   = 16;
    localparam int DLOG2   = 14;
    localparam int DEPTH   = 1 << DLOG2;
    localparam int BURST_N = 8192;

    logic   clk;
    logic   reset;
    state_t state;

    logic [OUT_W-1:0] exp_q[$];
    int checks;
    int errors;

    sample_burst_streamer_if #(
        .ADC_WIDTH       (ADC_W),
        .OUT_WIDTH       (OUT_W),
        .FIFO_DEPTH_LOG2 (DLOG2)
    ) bus ();

    sample_burst_streamer #(
        .ADC_WIDTH       (ADC_W),
        .OUT_WIDTH       (OUT_W),
        .FIFO_DEPTH_LOG2 (DLOG2),
        .BURST_WORDS     (BURST_N)
    ) dut (
        .inclk (clk),
        .reset (reset),
        .bus   (bus.slave),
        .state (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: n strobes starting at a negedge, data = base (+i when inc)
    task automatic push_words(input int n, input logic [ADC_W-1:0] base, input bit inc);
        logic [ADC_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = inc ? base + ADC_W'(i) : base;
            bus.sampleStrobe = 1'b1;
            bus.adcData      = d;
            if (exp_q.size() < DEPTH) exp_q.push_back(OUT_W'(d));
            @(negedge clk);
        end
        bus.sampleStrobe = 1'b0;
    endtask

    // driver + scoreboard: n consecutive pops, readData left high on return
    task automatic read_words(input int n);
        logic [OUT_W-1:0] e;
        for (int i = 0; i < n; i++) begin
            bus.readData = 1'b1;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            check_eq("read_word", 32'(bus.dataOut), 32'(e));
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_avail"}, 32'(bus.dataAvailable), 32'd0);
        check_eq({tag, "_dout"},  32'(bus.dataOut), 32'd0);
        check_eq({tag, "_ovf"},   32'(bus.overflow), 32'd0);
        check_eq({tag, "_unf"},   32'(bus.underflow), 32'd0);
        check_eq({tag, "_fill"},  32'(bus.fillLevel), 32'd0);
        check_eq({tag, "_state"}, 32'(state), 32'(IDLE));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.sampleStrobe = 1'b0;
        bus.adcData      = '0;
        bus.collectData  = 1'b0;
        bus.testMode     = 1'b0;
        bus.readData     = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // fill one burst of 0x2A5, then five marker words
        bus.collectData = 1'b1;
        push_words(BURST_N, 10'h2A5, 1'b0);
        check_eq("fill_8192", 32'(bus.fillLevel), 32'd8192);
        check_eq("avail_lag", 32'(bus.dataAvailable), 32'd0);
        @(negedge clk);
        check_eq("avail_set", 32'(bus.dataAvailable), 32'd1);
        check_eq("dout_2a5", 32'(bus.dataOut), 32'h02A5);
        check_eq("state_armed", 32'(state), 32'(ARMED));
        push_words(5, 10'h100, 1'b1);

        // one full burst
        read_words(1);
        check_eq("avail_drop", 32'(bus.dataAvailable), 32'd0);
        check_eq("state_burst", 32'(state), 32'(BURST));
        read_words(BURST_N - 1);
        bus.readData = 1'b0;
        check_eq("burst_exit", 32'(state), 32'(ARMED));
        check_eq("fill_after_burst", 32'(bus.fillLevel), 32'd5);
        check_eq("dout_marker", 32'(bus.dataOut), 32'h0100);
        @(negedge clk);
        check_eq("avail_reeval", 32'(bus.dataAvailable), 32'd0);

        // fill to capacity, overflow, then full push+pop
        push_words(DEPTH - 5, 10'h105, 1'b1);
        check_eq("fill_full", 32'(bus.fillLevel), 32'(DEPTH));
        check_eq("ovf_before", 32'(bus.overflow), 32'd0);
        push_words(1, 10'h3FF, 1'b0);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        check_eq("fill_still_full", 32'(bus.fillLevel), 32'(DEPTH));
        check_eq("dout_unchanged", 32'(bus.dataOut), 32'h0100);
        bus.sampleStrobe = 1'b1;
        bus.adcData      = 10'h3C3;
        bus.readData     = 1'b1;
        check_eq("full_pushpop_head", 32'(bus.dataOut), 32'(exp_q.pop_front()));
        exp_q.push_back(16'h03C3);
        @(negedge clk);
        bus.sampleStrobe = 1'b0;
        bus.readData     = 1'b0;
        check_eq("full_pushpop_fill", 32'(bus.fillLevel), 32'(DEPTH));
        check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
        read_words(DEPTH);
        bus.readData = 1'b0;
        check_eq("drained_fill", 32'(bus.fillLevel), 32'd0);
        check_eq("drained_dout", 32'(bus.dataOut), 32'd0);
        check_eq("drained_unf", 32'(bus.underflow), 32'd0);

        // underflow, push latency, flush
        bus.readData = 1'b1;
        @(negedge clk);
        bus.readData = 1'b0;
        check_eq("unf_dout", 32'(bus.dataOut), 32'd0);
        check_eq("unf_set", 32'(bus.underflow), 32'd1);
        check_eq("unf_fill", 32'(bus.fillLevel), 32'd0);
        push_words(1, 10'h011, 1'b0);
        check_eq("lat_fill", 32'(bus.fillLevel), 32'd1);
        check_eq("lat_dout_1clk", 32'(bus.dataOut), 32'd0);
        @(negedge clk);
        check_eq("lat_dout_2clk", 32'(bus.dataOut), 32'h0011);
        push_words(2, 10'h012, 1'b1);
        check_eq("preflush_fill", 32'(bus.fillLevel), 32'd3);
        bus.collectData  = 1'b0;
        bus.sampleStrobe = 1'b1;
        bus.adcData      = 10'h222;
        @(negedge clk);
        bus.sampleStrobe = 1'b0;
        check_idle_outputs("flush");
        exp_q.delete();

        // test pattern (or pass-through) words
        bus.collectData = 1'b1;
        bus.testMode    = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            bus.sampleStrobe = 1'b1;
            bus.adcData      = 10'h155;
`ifdef DD_TEST_PATTERN_EN
            exp_q.push_back(OUT_W'(i % 1024));
`else
            exp_q.push_back(16'h0155);
`endif
            @(negedge clk);
        end
        bus.sampleStrobe = 1'b0;
        bus.testMode     = 1'b0;
        check_eq("pattern_fill", 32'(bus.fillLevel), 32'd1030);
        @(negedge clk);
        read_words(1030);
        bus.readData = 1'b0;

        // reset in the middle of a burst
        push_words(BURST_N, 10'h000, 1'b1);
        @(negedge clk);
        check_eq("rst_avail_pre", 32'(bus.dataAvailable), 32'd1);
        read_words(10);
        check_eq("rst_state_pre", 32'(state), 32'(BURST));
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        bus.readData = 1'b0;
        exp_q.delete();
        push_words(20, 10'h040, 1'b1);
        @(negedge clk);
        check_eq("post_rst_fill", 32'(bus.fillLevel), 32'd20);
        check_eq("post_rst_avail", 32'(bus.dataAvailable), 32'd0);
        check_eq("post_rst_dout", 32'(bus.dataOut), 32'h0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
